// File: rtl/dm_access_seq.sv
// Data-memory access sequencer between the MEM stage and a single-port synchronous word RAM.
// Word stores write directly; partial stores read-modify-write; loads return the aligned word.
module dm_access_seq #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_read,
  input  logic              req_write,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata_out,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_re,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    StIdle, StRd, StCap, StWr, StRmwRd, StRmwMrg, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         merged;
  logic [2:0]          byte_sel;
  logic [1:0]          off;

  // Address bits above the RAM range alias modulo RAM size.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign off       = addr_q[1:0];
  assign ram_addr  = addr_q[ADDR_W+1:2];
  assign rdata_out = rdata_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

  // Big-endian merge: data byte d[n-1] lands on word byte off; bytes past byte 3 are dropped.
  always_comb begin
    merged   = ram_rdata;
    byte_sel = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if ((3'(k) >= {1'b0, off}) && (3'(k) < ({1'b0, off} + {1'b0, size_q}))) begin
        byte_sel = {1'b0, off} + {1'b0, size_q} - 3'd1 - 3'(k);
        merged[31-8*k -: 8] = wdata_q[{byte_sel[1:0], 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    rdata_d   = rdata_q;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = 32'd0;
    unique case (state_q)
      StIdle: begin
        if (req_write || req_read) begin
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          size_d  = req_size;
        end
        // A store wins over a simultaneous load; the load is dropped.
        if (req_write) begin
          state_d = (req_size == 2'd0) ? StWr : StRmwRd;
        end else if (req_read) begin
          state_d = StRd;
        end
      end
      StRd: begin
        ram_re  = 1'b1;
        state_d = StCap;
      end
      StCap: begin
        rdata_d = ram_rdata;
        state_d = StDone;
      end
      StWr: begin
        ram_we    = 1'b1;
        ram_wdata = wdata_q;
        state_d   = StDone;
      end
      StRmwRd: begin
        ram_re  = 1'b1;
        state_d = StRmwMrg;
      end
      StRmwMrg: begin
        ram_we    = 1'b1;
        ram_wdata = merged;
        state_d   = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dm_access_seq.sv
// Directed bench for dm_access_seq with a behavioural synchronous RAM and backdoor preload.
module tb_dm_access_seq;

  logic        CLK;
  logic        RESET;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_read, req_write;
  logic        busy, done;
  logic [31:0] rdata_out;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_re, ram_we;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:1023];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;
  int          we_cnt;
  int          both_cnt;
  int          n_cmp;
  int          n_err;

  dm_access_seq #(.ADDR_W(10)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_size (req_size),
    .req_read (req_read),
    .req_write(req_write),
    .busy     (busy),
    .done     (done),
    .rdata_out(rdata_out),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_re   (ram_re),
    .ram_we   (ram_we),
    .ram_rdata(ram_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
    if (ram_we) we_cnt = we_cnt + 1;
    if (ram_we && ram_re) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    step();
    bd_we = 1'b0;
  endtask

  // Issues one request, drops it after the accept edge, returns at the done cycle.
  task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         input logic rd, input logic wr, output int lat);
    req_addr = a; req_wdata = d; req_size = s; req_read = rd; req_write = wr;
    step();
    req_read = 1'b0; req_write = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      step();
      lat++;
    end
  endtask

  int lat;
  int we0;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; we_cnt = 0; both_cnt = 0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    RESET = 1'b0;
    req_addr = '0; req_wdata = '0; req_size = '0; req_read = 1'b0; req_write = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_re_we", {30'd0, ram_re, ram_we}, 32'd0);
    check("rst_rdata", rdata_out, 32'd0);
    check("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    step();
    RESET = 1'b1;
    step();

    // Load: re at +1, done at +3, busy for three cycles.
    preload(10'd4, 32'h11223344);
    req_addr = 32'h10; req_read = 1'b1;
    step();
    req_read = 1'b0;
    check("ld_c1_re", {30'd0, ram_re, busy}, 32'd3);
    check("ld_c1_addr", {22'd0, ram_addr}, 32'd4);
    step();
    check("ld_c2", {29'd0, ram_re, busy, done}, 32'd2);
    step();
    check("ld_c3", {29'd0, ram_re, busy, done}, 32'd3);
    check("ld_rdata", rdata_out, 32'h11223344);
    step();
    check("ld_c4_idle", {30'd0, busy, done}, 32'd0);

    // Reset during the merge write cycle must abort with no write.
    preload(10'd4, 32'h11223344);
    we0 = we_cnt;
    req_addr = 32'h11; req_wdata = 32'hAB; req_size = 2'd1; req_write = 1'b1;
    step();
    req_write = 1'b0;
    check("rmw_rd_re", {31'd0, ram_re}, 32'd1);
    step();
    check("rmw_mrg_we", {31'd0, ram_we}, 32'd1);
    #1 RESET = 1'b0;
    #1;
    check("rstmid_busy_we", {30'd0, busy, ram_we}, 32'd0);
    step();
    step();
    RESET = 1'b1;
    step();
    check("rstmid_we_cnt", we_cnt, we0);
    check("rstmid_mem", mem[4], 32'h11223344);
    check("rstmid_rdata", rdata_out, 32'd0);

    // Word store ignores low address bits; one write, done at +2.
    we0 = we_cnt;
    run_req(32'h13, 32'hCAFEDEAD, 2'd0, 1'b0, 1'b1, lat);
    check("sw_lat", lat, 2);
    check("sw_mem", mem[4], 32'hCAFEDEAD);
    check("sw_we_cnt", we_cnt - we0, 1);
    step();

    preload(10'd4, 32'h11223344);
    run_req(32'h11, 32'h000000AB, 2'd1, 1'b0, 1'b1, lat);
    check("sb_lat", lat, 3);
    check("sb_mem", mem[4], 32'h11AB3344);
    step();

    preload(10'd4, 32'h11223344);
    run_req(32'h12, 32'h0000BEEF, 2'd2, 1'b0, 1'b1, lat);
    check("sh_mem", mem[4], 32'h1122BEEF);
    step();

    preload(10'd4, 32'h11223344);
    run_req(32'h11, 32'h00ABCDEF, 2'd3, 1'b0, 1'b1, lat);
    check("s3_lat", lat, 3);
    check("s3_mem", mem[4], 32'h11ABCDEF);
    step();

    // Half store at offset 3 drops the byte that would spill into the next word.
    preload(10'd4, 32'h11223344);
    preload(10'd5, 32'h55667788);
    run_req(32'h13, 32'h0000BEEF, 2'd2, 1'b0, 1'b1, lat);
    check("trunc_mem4", mem[4], 32'h112233BE);
    check("trunc_mem5", mem[5], 32'h55667788);
    step();

    // Simultaneous read/write: store only; then a read held through DONE is taken one cycle later.
    preload(10'd4, 32'h11223344);
    run_req(32'h10, 32'h00000077, 2'd1, 1'b1, 1'b1, lat);
    check("rw_lat", lat, 3);
    check("rw_mem", mem[4], 32'h77223344);
    check("rw_rdata_kept", rdata_out, 32'd0);
    req_addr = 32'h10; req_read = 1'b1;
    step();
    check("b2b_idle_gap", {30'd0, busy, ram_re}, 32'd0);
    step();
    req_read = 1'b0;
    check("b2b_accept", {30'd0, busy, ram_re}, 32'd3);
    step();
    step();
    check("b2b_done", {31'd0, done}, 32'd1);
    check("b2b_rdata", rdata_out, 32'h77223344);
    step();

    // Alias: address beyond RAM size maps modulo RAM size.
    run_req(32'h0000_1010, 32'h0, 2'd0, 1'b1, 1'b0, lat);
    check("alias_rdata", rdata_out, 32'h77223344);
    step();

    check("re_we_exclusive", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
